// File: rtl/clint_vec_pkg.sv
// Shared definitions for the vectored core-local interrupt controller:
// sequencer states, cause codes, CSR addresses, instruction encodings and
// privilege codes.
package clint_vec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMepc,
    StMstatus,
    StMcause,
    StMret
  } state_e;

  // Synchronous exception cause codes
  localparam int unsigned CauseIllegal = 2;
  localparam int unsigned CauseEbreak  = 3;
  localparam int unsigned CauseEcallU  = 8;
  localparam int unsigned CauseEcallM  = 11;

  // CSR addresses
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  // Instruction encodings
  localparam logic [31:0] InsEcall     = 32'h0000_0073;
  localparam logic [31:0] InsEbreak    = 32'h0010_0073;
  localparam logic [31:0] InsMret      = 32'h3020_0073;
  localparam logic [6:0]  OpSystem     = 7'b1110011;
  localparam logic [6:0]  OpReg        = 7'b0110011;
  localparam logic [6:0]  Funct7MulDiv = 7'b0000001;

  // Privilege levels
  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivM = 2'b11;

  // Index width for a vector of n sources; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clint_vec_irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the masked request vector wins.
// Ports:
//   req_i   - masked interrupt requests
//   valid_o - any request set
//   idx_o   - binary index of the lowest set request
module clint_vec_irq_prio_enc #(
  parameter int unsigned NumIrq = 8,
  parameter int unsigned IdxW   = 3
) (
  input  logic [NumIrq-1:0] req_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the lowest index is the last (winning) assignment.
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller with multi-source fixed-priority arbitration.
// Takes sync exceptions, masked level interrupts and mret, sequences the
// mepc/mstatus/mcause writes and redirects the pipeline.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   ins_i, ins_addr_i           - instruction in execute and its address
//   jump_flag_i, jump_addr_i    - execute is jumping, and its target
//   div_req_i, div_busy_i       - divider handshake
//   irq_i                       - level interrupt requests
//   csr_*_i, privilege_i        - current CSR state
//   wr_en_o/addr_o/data_o       - CSR write port
//   wr_privilege_en_o/_o        - privilege update
//   mip_o                       - pending view of irq_i
//   irq_ack_o                   - one-hot acknowledge of the taken source
//   clint_busy_o                - pipeline stall
//   int_assert_o, int_addr_o    - redirect pulse and target
module clint_vec
  import clint_vec_pkg::*;
#(
  parameter int unsigned NUM_IRQ        = 8,
  parameter int unsigned IRQ_CAUSE_BASE = 16,
  parameter int unsigned XLEN           = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    ins_i,
  input  logic [XLEN-1:0]    ins_addr_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic               div_req_i,
  input  logic               div_busy_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  input  logic [XLEN-1:0]    csr_mie_i,
  input  logic [1:0]         privilege_i,
  output logic               wr_en_o,
  output logic [XLEN-1:0]    wr_addr_o,
  output logic [XLEN-1:0]    wr_data_o,
  output logic               wr_privilege_en_o,
  output logic [1:0]         wr_privilege_o,
  output logic [XLEN-1:0]    mip_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               clint_busy_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o
);

  localparam int unsigned IdxW = idx_width(NUM_IRQ);

  state_e              state_q;
  logic [XLEN-1:0]     div_addr_q, cause_q, epc_q;
  logic [IdxW-1:0]     idx_q;
  logic                async_q;
  logic                wr_en_q, wr_priv_en_q, int_assert_q;
  logic [XLEN-1:0]     wr_addr_q, wr_data_q, int_addr_q;
  logic [1:0]          wr_priv_q;
  logic [NUM_IRQ-1:0]  irq_ack_q;

  // Instruction decode
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_ecall, is_ebreak, is_illegal, is_mret, is_div;
  assign opcode     = ins_i[6:0];
  assign funct3     = ins_i[14:12];
  assign funct7     = ins_i[31:25];
  assign is_ecall   = ins_i[31:0] == InsEcall;
  assign is_ebreak  = ins_i[31:0] == InsEbreak;
  assign is_mret    = ins_i[31:0] == InsMret;
  assign is_illegal = (opcode == OpSystem) && (funct3 != 3'b000) && (privilege_i == PrivU);
  assign is_div     = (opcode == OpReg) && (funct7 == Funct7MulDiv) && funct3[2];

  // Interrupt masking and pending view
  logic [NUM_IRQ-1:0] mie_en;
  logic [XLEN-1:0]    mip;
  always_comb begin
    mip = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      mie_en[i]                = csr_mie_i[IRQ_CAUSE_BASE + i];
      mip[IRQ_CAUSE_BASE + i]  = irq_i[i];
    end
  end

  logic            irq_valid;
  logic [IdxW-1:0] irq_idx;
  clint_vec_irq_prio_enc #(
    .NumIrq(NUM_IRQ),
    .IdxW  (IdxW)
  ) u_prio_enc (
    .req_i  (irq_i & mie_en),
    .valid_o(irq_valid),
    .idx_o  (irq_idx)
  );

  // A sync exception waits for jump/div to clear but does not hold off async.
  logic sync_go, async_go, accept;
  assign sync_go  = (is_ecall | is_ebreak | is_illegal) & ~jump_flag_i & ~div_req_i;
  assign async_go = irq_valid & csr_mstatus_i[3];
  assign accept   = (state_q == StIdle) & (sync_go | async_go | is_mret);

  logic [XLEN-1:0] sync_cause, async_code, async_epc;
  always_comb begin
    if (is_ecall)       sync_cause = (privilege_i == PrivM) ? XLEN'(CauseEcallM) : XLEN'(CauseEcallU);
    else if (is_ebreak) sync_cause = XLEN'(CauseEbreak);
    else                sync_cause = XLEN'(CauseIllegal);
    async_code = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);
    if (jump_flag_i)                  async_epc = jump_addr_i;
    else if (div_req_i | div_busy_i)  async_epc = div_addr_q;
    else                              async_epc = ins_addr_i;
  end

  // CSR write data and redirect target
  logic [XLEN-1:0] mstatus_entry, mstatus_mret, tvec_base, entry_addr;
  always_comb begin
    mstatus_entry        = csr_mstatus_i;
    mstatus_entry[12:11] = privilege_i;
    mstatus_entry[7]     = csr_mstatus_i[3];
    mstatus_entry[3]     = 1'b0;
    mstatus_mret         = csr_mstatus_i;
    mstatus_mret[3]      = csr_mstatus_i[7];
    mstatus_mret[7]      = 1'b1;
    mstatus_mret[12:11]  = PrivU;
    tvec_base            = {csr_mtvec_i[XLEN-1:2], 2'b00};
    if ((csr_mtvec_i[1:0] == 2'b01) && async_q) begin
      entry_addr = tvec_base + ((XLEN'(IRQ_CAUSE_BASE) + XLEN'(idx_q)) << 2);
    end else begin
      entry_addr = tvec_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      div_addr_q   <= '0;
      cause_q      <= '0;
      epc_q        <= '0;
      idx_q        <= '0;
      async_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_priv_en_q <= 1'b0;
      wr_priv_q    <= PrivM;
      irq_ack_q    <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_priv_en_q <= 1'b0;
      irq_ack_q    <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
      if (is_div) div_addr_q <= ins_addr_i;
      case (state_q)
        StIdle: begin
          if (sync_go) begin
            cause_q <= sync_cause;
            epc_q   <= ins_addr_i;
            async_q <= 1'b0;
            state_q <= StMepc;
          end else if (async_go) begin
            cause_q   <= {1'b1, async_code[XLEN-2:0]};
            epc_q     <= async_epc;
            idx_q     <= irq_idx;
            async_q   <= 1'b1;
            irq_ack_q <= NUM_IRQ'(1) << irq_idx;
            state_q   <= StMepc;
          end else if (is_mret) begin
            state_q <= StMret;
          end
        end
        StMepc: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= XLEN'(CsrMepc);
          wr_data_q <= epc_q;
          state_q   <= StMstatus;
        end
        StMstatus: begin
          wr_en_q      <= 1'b1;
          wr_addr_q    <= XLEN'(CsrMstatus);
          wr_data_q    <= mstatus_entry;
          wr_priv_en_q <= 1'b1;
          wr_priv_q    <= PrivM;
          state_q      <= StMcause;
        end
        StMcause: begin
          wr_en_q      <= 1'b1;
          wr_addr_q    <= XLEN'(CsrMcause);
          wr_data_q    <= cause_q;
          int_assert_q <= 1'b1;
          int_addr_q   <= entry_addr;
          state_q      <= StIdle;
        end
        StMret: begin
          wr_en_q      <= 1'b1;
          wr_addr_q    <= XLEN'(CsrMstatus);
          wr_data_q    <= mstatus_mret;
          wr_priv_en_q <= 1'b1;
          wr_priv_q    <= csr_mstatus_i[12:11];
          int_assert_q <= 1'b1;
          int_addr_q   <= csr_mepc_i;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // int_assert_q covers the final output cycle, when the state is already idle.
  assign clint_busy_o      = ~rst & ((state_q != StIdle) | accept | int_assert_q);
  assign wr_en_o           = wr_en_q;
  assign wr_addr_o         = wr_addr_q;
  assign wr_data_o         = wr_data_q;
  assign wr_privilege_en_o = wr_priv_en_q;
  assign wr_privilege_o    = wr_priv_q;
  assign mip_o             = mip;
  assign irq_ack_o         = irq_ack_q;
  assign int_assert_o      = int_assert_q;
  assign int_addr_o        = int_addr_q;

  // Only the per-source enable bits of mie are looked at.
  logic unused_mie;
  assign unused_mie = ^csr_mie_i;

endmodule

// File: doc/clint_vec.md
Name: clint_vec

Overview:
- Parametrised successor to the core-local interrupt controller.
- Arbitrates synchronous exceptions (ecall/ebreak/illegal CSR access from U-mode), NUM_IRQ masked level-sensitive interrupt sources, and mret.
- Sequences the mepc/mstatus/mcause CSR writes, then redirects the pipeline via int_assert_o/int_addr_o.
- Adds fixed-priority multi-source arbitration, mie masking, MPIE save/restore, vectored mtvec mode and per-source acknowledge.

Parameters:
- NUM_IRQ, 8, number of asynchronous interrupt sources (1..16).
- IRQ_CAUSE_BASE, 16, mcause code of irq_i[0]; source i uses code IRQ_CAUSE_BASE+i.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ins_i  in  XLEN  instruction in execute
- ins_addr_i  in  XLEN  its address
- jump_flag_i  in  1  execute is taking a jump
- jump_addr_i  in  XLEN  jump target
- div_req_i  in  1  divide request
- div_busy_i  in  1  divider busy
- irq_i  in  NUM_IRQ  level interrupt requests
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i / csr_mie_i  in  XLEN  current CSR values
- privilege_i  in  2  current privilege level
- wr_en_o  out  1  CSR write enable
- wr_addr_o  out  XLEN  CSR write address
- wr_data_o  out  XLEN  CSR write data
- wr_privilege_en_o  out  1  privilege update strobe
- wr_privilege_o  out  2  new privilege level
- mip_o  out  XLEN  pending view (irq_i at bit IRQ_CAUSE_BASE+i, others 0), combinational
- irq_ack_o  out  NUM_IRQ  one-hot pulse marking the source taken
- clint_busy_o  out  1  controller busy, stalls the pipeline
- int_assert_o  out  1  redirect pulse
- int_addr_o  out  XLEN  redirect target

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; all outputs are 0, except wr_privilege_o=2'b11.
  - Internal div_addr, cause and epc registers are 0.
  - Reset mid-sequence abandons the sequence; no partial writes occur after rst falls.
- div_addr: registered from ins_addr_i whenever ins_i decodes as div/divu/rem/remu.
- Request decode in IDLE, cycle T (combinational). Priority, highest first:
  1. sync = ecall | ebreak | (opcode 7'b1110011 with funct3!=0 and privilege_i==U). Deferred (no action) while jump_flag_i or div_req_i is 1.
  2. async = |(irq_i & mie_en) with mstatus[3]=1. mie_en[i]=csr_mie_i[IRQ_CAUSE_BASE+i]. The lowest enabled index wins.
  3. mret.
- Cause codes:
  - ecall 11 (M) or 8 (U)
  - ebreak 3
  - illegal 2
  - async {1'b1, IRQ_CAUSE_BASE+idx}
- epc capture for sync: ins_addr_i.
- epc capture for async:
  - jump_flag_i: jump_addr_i
  - else div_req_i|div_busy_i: div_addr
  - else ins_addr_i
- Latching: cause, epc and winning index latch at the T edge. Later changes of irq_i do not alter the sequence.
- irq_ack_o: one-hot of the winner, visible T+1 for one cycle.
- Entry states: IDLE -> MEPC (T+1) -> MSTATUS (T+2) -> MCAUSE (T+3) -> IDLE. Outputs are registered from state, so:
  - T+2: wr mepc=epc.
  - T+3: wr mstatus = MPP<=privilege_i, MPIE<=MIE, MIE<=0, other bits kept; wr_privilege_en_o=1, wr_privilege_o=M.
  - T+4: wr mcause=cause; int_assert_o=1.
- int_addr_o on entry:
  - Base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==2'b01 and the request is async: base + 4*(IRQ_CAUSE_BASE+idx).
  - Otherwise: base.
- MRET: IDLE -> MRET (T+1) -> IDLE.
  - At T+2: wr mstatus = MIE<=MPIE, MPIE<=1, MPP<=U; wr_privilege_o=old MPP, en=1.
  - At T+2: int_assert_o=1, int_addr_o=csr_mepc_i.
- clint_busy_o = (state!=IDLE) | a request being accepted in IDLE this cycle. It stays high through the final output cycle.
- Non-write cycles: wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_privilege_en_o=0, int_assert_o=0, int_addr_o=0.
- New requests are ignored while not in IDLE; level irqs are re-evaluated on return to IDLE.
- Simultaneous events:
  - sync beats async; async beats mret.
  - A deferred sync blocked by jump/div does not block async that cycle.

Decomposition:
- Shared package/defines:
  - State encodings (IDLE, MEPC, MSTATUS, MCAUSE, MRET)
  - Cause codes
  - CSR addresses (mepc 0x341, mcause 0x342, mstatus 0x300)
  - Instruction encodings (ECALL, EBREAK, MRET, DIV*)
  - Privilege codes (U=2'b00, M=2'b11)
- Sub-module irq_prio_enc: NUM_IRQ masked vector -> valid + lowest-index binary idx.

Test Plan:
- irq_i=8'b0010_0100, mie bits 18 and 21 set, MIE=1, mtvec=0x100 direct, ins_addr=0x80 -> T+2 mepc=0x80; T+4 mcause=0x80000012, int_addr=0x100; irq_ack_o=8'b0000_0100 at T+1.
- Same with mtvec=0x101 -> int_addr=0x100+4*18=0x148; mstatus write has MPIE=1, MIE=0, MPP=old privilege.
- ecall at 0x40 with jump_flag_i=1 for 2 cycles -> no activity; jump drops -> mcause=11, mepc=0x40.
- div in flight (div_busy_i=1, div at 0x20), irq fires, ins_addr_i=0x28 -> mepc=0x20.
- mret, mstatus MPIE=1, MPP=U, mepc=0x200 -> T+2: mstatus MIE=1, MPP=U, wr_privilege_o=U, int_addr=0x200.
- rst asserted at T+2 of an entry sequence -> all outputs 0 immediately; no mcause write after release; busy=0.
